regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the single register-file write port (WE3/A3/WD3) between NREQ
//   writeback requesters, for example ALU result, load data and multiplier.
//   Each requester uses a valid/ready handshake. Arbitration is round-robin.
//   The winner is registered onto the port one cycle later.
//   Writes to the PC address are steered to a separate PC write port,
//   because the register file does not store R15.
// PARAMETERS
//   NREQ     3    number of requesters (2..8)
//   AW       4    register address width
//   DW       32   data width
//   PC_ADDR  15   address redirected to PC_WE/PC_WD instead of WE3
// PORTS
//   CLK        in   1         rising-edge clock
//   RST_N      in   1         asynchronous active-low reset
//   REQ_VALID  in   NREQ      requester i has a write pending
//   REQ_ADDR   in   NREQ*AW   dest address; slice i = [i*AW +: AW]
//   REQ_DATA   in   NREQ*DW   write data; slice i = [i*DW +: DW]
//   REQ_READY  out  NREQ      one-hot grant; write accepted when VALID&READY
//   HOLD       in   1         pipeline stall; blocks all grants this cycle
//   WE3        out  1         register-file write enable (registered)
//   A3         out  AW        register-file write address (registered)
//   WD3        out  DW        register-file write data (registered)
//   PC_WE      out  1         PC write enable (registered)
//   PC_WD      out  DW        PC write data (registered)
//   PTR        out  clog2(NREQ)  current round-robin priority pointer (debug)
// BEHAVIOUR
//   Reset (RST_N=0, acts immediately):
//     - WE3=0, A3=0, WD3=0, PC_WE=0, PC_WD=0, PTR=0.
//     - REQ_READY forced to all-zero.
//   Grant logic (combinational):
//     - Scan i = PTR, PTR+1, ... modulo NREQ.
//     - The first i with REQ_VALID[i]=1 gets REQ_READY[i]=1.
//     - REQ_READY is at most one-hot.
//     - REQ_READY is all-zero if HOLD=1, RST_N=0 or no request is valid.
//     - REQ_READY never depends on REQ_ADDR or REQ_DATA.
//   Pointer update (registered):
//     - On a grant to index g: PTR <= (g+1) mod NREQ.
//     - No grant: PTR holds.
//     - Worst-case wait for a valid requester is NREQ-1 grants.
//   Output stage (registered, latency exactly 1 cycle from acceptance):
//     - Grant g with addr != PC_ADDR: WE3<=1, A3<=addr_g, WD3<=data_g, PC_WE<=0.
//     - Grant g with addr == PC_ADDR: PC_WE<=1, PC_WD<=data_g, WE3<=0.
//       A3 and WD3 hold their previous values.
//     - No grant: WE3<=0 and PC_WE<=0; A3, WD3 and PC_WD hold.
//     - WE3 and PC_WE are never both 1.
//   Throughput: one write per cycle when any requester is valid and HOLD=0.
//   Handshake rules for requesters:
//     - Once VALID is raised, addr/data must stay stable until accepted.
//     - VALID must not drop before acceptance.
//     - The arbiter keeps no state per requester, so a dropped request is lost.
//   Same-address requests in one cycle:
//     - Both are written in grant order; the later grant wins in the file.
//   HOLD behaviour:
//     - HOLD=1 suppresses new grants only.
//     - An already-registered write still presents WE3 in that cycle.
//   Reset mid-operation:
//     - A write in the output stage is discarded; WE3/PC_WE drop to 0 at once.
//     - Un-accepted requests are granted again after reset, starting from PTR=0.
// TESTING
//   1. NREQ=3, all VALID=1, addrs 1/2/3, PTR=0 -> READY one-hot 001,010,100,001...
//      WE3=1 every cycle, A3 sequence 1,2,3,1, lagging acceptance by 1 cycle.
//   2. Only req1 valid, addr=15, data=0x0000_0100 -> next cycle PC_WE=1,
//      PC_WD=0x100, WE3=0, A3/WD3 unchanged.
//   3. req0 valid with HOLD=1 for 3 cycles -> READY=0, WE3=0, PTR unchanged;
//      HOLD=0 -> READY[0]=1 the same cycle, WE3=1 the next cycle, PTR=1.
//   4. PTR=0, only req2 valid (addr 7, data 0xDEAD_BEEF) -> READY=100 at once,
//      next cycle WE3=1, A3=7, WD3=0xDEADBEEF, PTR=0.
//   5. req0 and req1 both write addr 5 (data 0xA, then 0xB), PTR=0 ->
//      WD3=0xA then 0xB on consecutive cycles; register 5 ends at 0xB.
//   6. RST_N pulsed low asynchronously mid-cycle while WE3=1 -> WE3, PC_WE and
//      READY go to 0 without a clock edge; PTR=0 after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources.
// Writes to PC_ADDR are diverted to a dedicated PC write port.
module regfile_write_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int PC_ADDR = 15
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ*AW-1:0]        REQ_ADDR,
  input  logic [NREQ*DW-1:0]        REQ_DATA,
  output logic [NREQ-1:0]           REQ_READY,
  input  logic                      HOLD,
  output logic                      WE3,
  output logic [AW-1:0]             A3,
  output logic [DW-1:0]             WD3,
  output logic                      PC_WE,
  output logic [DW-1:0]             PC_WD,
  output logic [$clog2(NREQ)-1:0]   PTR
);

  localparam int PW = $clog2(NREQ);

  logic            found_hi, found_lo;
  logic [PW-1:0]   idx_hi, idx_lo;
  logic [PW-1:0]   gnt_p0;
  logic [PW-1:0]   ptr_nxt_p0;
  logic            vld_p0;
  logic [NREQ-1:0] ready_p0;
  logic [AW-1:0]   sel_addr_p0;
  logic [DW-1:0]   sel_data_p0;
  logic            is_pc_p0;

  // Stage p0: combinational grant. The first valid index at or above PTR wins;
  // failing that, the lowest valid index below PTR (the wrap-around).
  always_comb begin
    found_hi    = 1'b0;
    found_lo    = 1'b0;
    idx_hi      = '0;
    idx_lo      = '0;
    ready_p0    = '0;
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (REQ_VALID[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = PW'(i);
      end
      if (REQ_VALID[i] && !found_hi && (PW'(i) >= PTR)) begin
        found_hi = 1'b1;
        idx_hi   = PW'(i);
      end
    end
    gnt_p0     = found_hi ? idx_hi : idx_lo;
    vld_p0     = found_lo && !HOLD && RST_N;
    ptr_nxt_p0 = (gnt_p0 == PW'(NREQ-1)) ? '0 : gnt_p0 + 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ready_p0[i] = vld_p0 && (PW'(i) == gnt_p0);
      if (ready_p0[i]) begin
        sel_addr_p0 = REQ_ADDR[i*AW +: AW];
        sel_data_p0 = REQ_DATA[i*DW +: DW];
      end
    end
    is_pc_p0 = (sel_addr_p0 == AW'(PC_ADDR));
  end

  assign REQ_READY = ready_p0;

  // Stage p1: registered write port, PC port and priority pointer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WE3   <= 1'b0;
      A3    <= '0;
      WD3   <= '0;
      PC_WE <= 1'b0;
      PC_WD <= '0;
      PTR   <= '0;
    end else begin
      WE3   <= vld_p0 && !is_pc_p0;
      PC_WE <= vld_p0 && is_pc_p0;
      if (vld_p0) begin
        PTR <= ptr_nxt_p0;
        if (is_pc_p0) begin
          PC_WD <= sel_data_p0;
        end else begin
          A3  <= sel_addr_p0;
          WD3 <= sel_data_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=3, AW=4, DW=32, PC_ADDR=15).
module tb_regfile_write_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [2:0]  REQ_VALID;
  logic [11:0] REQ_ADDR;
  logic [95:0] REQ_DATA;
  logic [2:0]  REQ_READY;
  logic        HOLD;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        PC_WE;
  logic [31:0] PC_WD;
  logic [1:0]  PTR;

  int total  = 0;
  int passed = 0;

  regfile_write_arbiter #(.NREQ(3), .AW(4), .DW(32), .PC_ADDR(15)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .HOLD(HOLD), .WE3(WE3),
    .A3(A3), .WD3(WD3), .PC_WE(PC_WE), .PC_WD(PC_WD), .PTR(PTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v,
                         input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    REQ_VALID = v;
    REQ_ADDR  = {a2, a1, a0};
    REQ_DATA  = {d2, d1, d0};
  endtask

  logic [2:0] exp_rdy [4];
  logic [3:0] exp_a3  [4];
  logic [1:0] exp_ptr [4];

  initial begin
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a3  = '{4'd1, 4'd2, 4'd3, 4'd1};
    exp_ptr = '{2'd1, 2'd2, 2'd0, 2'd1};

    RST_N = 1'b0;
    HOLD  = 1'b0;
    set_req(3'b111, 4'd1, 4'd2, 4'd3, 32'h11, 32'h22, 32'h33);
    #1;
    check("rst_ready", {29'd0, REQ_READY}, 32'd0);
    check("rst_we3",   {31'd0, WE3}, 32'd0);
    check("rst_a3",    {28'd0, A3}, 32'd0);
    check("rst_wd3",   WD3, 32'd0);
    check("rst_pcwe",  {31'd0, PC_WE}, 32'd0);
    check("rst_pcwd",  PC_WD, 32'd0);
    check("rst_ptr",   {30'd0, PTR}, 32'd0);
    tick();
    check("rst_hold_we3", {31'd0, WE3}, 32'd0);
    RST_N = 1'b1;
    #1;

    // Round-robin over three always-valid requesters
    for (int k = 0; k < 4; k++) begin
      check("rr_ready", {29'd0, REQ_READY}, {29'd0, exp_rdy[k]});
      tick();
      check("rr_we3", {31'd0, WE3}, 32'd1);
      check("rr_a3",  {28'd0, A3}, {28'd0, exp_a3[k]});
      check("rr_wd3", WD3, 32'h11 * {28'd0, exp_a3[k]});
      check("rr_pcwe", {31'd0, PC_WE}, 32'd0);
      check("rr_ptr", {30'd0, PTR}, {30'd0, exp_ptr[k]});
    end
    REQ_VALID = 3'b000;
    #1;
    check("idle_ready", {29'd0, REQ_READY}, 32'd0);
    tick();
    check("idle_we3", {31'd0, WE3}, 32'd0);
    check("idle_a3_hold", {28'd0, A3}, 32'd1);
    check("idle_ptr", {30'd0, PTR}, 32'd1);

    // PC redirect
    set_req(3'b010, 4'd0, 4'd15, 4'd0, 32'h0, 32'h0000_0100, 32'h0);
    #1;
    check("pc_ready", {29'd0, REQ_READY}, 32'b010);
    tick();
    REQ_VALID = 3'b000;
    check("pc_pcwe", {31'd0, PC_WE}, 32'd1);
    check("pc_pcwd", PC_WD, 32'h100);
    check("pc_we3",  {31'd0, WE3}, 32'd0);
    check("pc_a3",   {28'd0, A3}, 32'd1);
    check("pc_wd3",  WD3, 32'h11);
    check("pc_ptr",  {30'd0, PTR}, 32'd2);
    tick();
    check("pc_pcwe_drop", {31'd0, PC_WE}, 32'd0);
    check("pc_pcwd_hold", PC_WD, 32'h100);

    // HOLD blocks grants; release grants in the same cycle
    set_req(3'b001, 4'd4, 4'd0, 4'd0, 32'h44, 32'h0, 32'h0);
    HOLD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", {29'd0, REQ_READY}, 32'd0);
      tick();
      check("hold_we3", {31'd0, WE3}, 32'd0);
      check("hold_ptr", {30'd0, PTR}, 32'd2);
    end
    HOLD = 1'b0;
    #1;
    check("unhold_ready", {29'd0, REQ_READY}, 32'b001);
    tick();
    REQ_VALID = 3'b000;
    check("unhold_we3", {31'd0, WE3}, 32'd1);
    check("unhold_a3",  {28'd0, A3}, 32'd4);
    check("unhold_ptr", {30'd0, PTR}, 32'd1);

    // Only req2 valid: first from PTR=1, then again from PTR=0
    set_req(3'b100, 4'd0, 4'd0, 4'd7, 32'h0, 32'h0, 32'hDEAD_BEEF);
    #1;
    check("r2a_ready", {29'd0, REQ_READY}, 32'b100);
    tick();
    check("r2a_ptr", {30'd0, PTR}, 32'd0);
    check("r2b_ready", {29'd0, REQ_READY}, 32'b100);
    tick();
    check("r2b_we3", {31'd0, WE3}, 32'd1);
    check("r2b_a3",  {28'd0, A3}, 32'd7);
    check("r2b_wd3", WD3, 32'hDEAD_BEEF);
    check("r2b_ptr", {30'd0, PTR}, 32'd0);
    HOLD = 1'b1;
    #1;
    check("hold_ready_busy", {29'd0, REQ_READY}, 32'd0);
    check("hold_we3_busy", {31'd0, WE3}, 32'd1);
    tick();
    check("hold_we3_after", {31'd0, WE3}, 32'd0);
    REQ_VALID = 3'b000;
    HOLD = 1'b0;

    // Same address from req0 and req1, grant order 0 then 1
    set_req(3'b011, 4'd5, 4'd5, 4'd0, 32'hA, 32'hB, 32'h0);
    #1;
    check("same_ready0", {29'd0, REQ_READY}, 32'b001);
    tick();
    REQ_VALID = 3'b010;
    check("same_wd3_a", WD3, 32'hA);
    check("same_a3_a",  {28'd0, A3}, 32'd5);
    #1;
    check("same_ready1", {29'd0, REQ_READY}, 32'b010);
    tick();
    REQ_VALID = 3'b000;
    check("same_wd3_b", WD3, 32'hB);
    check("same_a3_b",  {28'd0, A3}, 32'd5);
    check("same_ptr",   {30'd0, PTR}, 32'd2);

    // Asynchronous reset while a write is in the output stage
    set_req(3'b111, 4'd1, 4'd2, 4'd3, 32'h11, 32'h22, 32'h33);
    #1;
    check("ar_ready", {29'd0, REQ_READY}, 32'b100);
    tick();
    check("ar_we3_pre", {31'd0, WE3}, 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_we3",   {31'd0, WE3}, 32'd0);
    check("ar_pcwe",  {31'd0, PC_WE}, 32'd0);
    check("ar_ready0", {29'd0, REQ_READY}, 32'd0);
    check("ar_ptr",   {30'd0, PTR}, 32'd0);
    #2;
    RST_N = 1'b1;
    #1;
    check("ar_ready_rel", {29'd0, REQ_READY}, 32'b001);
    tick();
    check("ar_we3_rel", {31'd0, WE3}, 32'd1);
    check("ar_a3_rel",  {28'd0, A3}, 32'd1);
    check("ar_ptr_rel", {30'd0, PTR}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
